// File: rtl/dm9000a_iow.sv
// DM9000A register-write bus engine: one index/data pair per start request,
// driven out as an index write (CMD=0) followed by a data write (CMD=1).
module dm9000a_iow #(
  parameter int unsigned TSU  = 1,  // setup cycles before IOW# falls
  parameter int unsigned TPW  = 2,  // IOW# low cycles
  parameter int unsigned THD  = 1,  // hold cycles after IOW# rises
  parameter int unsigned TGAP = 2   // idle cycles between index and data phases
) (
  input  logic        iDm9000aClk,
  input  logic        iReset,
  input  logic        iRunStart,
  input  logic [15:0] iReg,
  input  logic [15:0] iData,
  output logic        oRunEnd,
  output logic        oBusy,
  output logic        oCs_n,
  output logic        oCmd,
  output logic        oIow_n,
  output logic        oIor_n,
  output logic [15:0] oSd,
  output logic        oSdOe
);

  localparam int unsigned CntW  = 8;
  localparam int unsigned DataW = 16;

  typedef enum logic [3:0] {
    Idle  = 4'd0,
    IdxSu = 4'd1,
    IdxPw = 4'd2,
    IdxHd = 4'd3,
    Gap   = 4'd4,
    DatSu = 4'd5,
    DatPw = 4'd6,
    DatHd = 4'd7,
    Done  = 4'd8
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CntW-1:0]  cnt;
  logic [CntW-1:0]  cntLoad;
  logic [DataW-1:0] regLatch;
  logic [DataW-1:0] dataLatch;

  logic             runEndNext;
  logic             busyNext;
  logic             csNNext;
  logic             cmdNext;
  logic             iowNNext;
  logic [DataW-1:0] sdNext;
  logic             sdOeNext;

  // State register and per-state down counter (reloaded on every state change)
  always_ff @(posedge iDm9000aClk or posedge iReset) begin
    if (iReset) begin
      state <= Idle;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (nextState != state) begin
        cnt <= cntLoad;
      end else if (cnt != '0) begin
        cnt <= cnt - CntW'(1);
      end
    end
  end

  // Next-state: timed states advance when the counter expires
  always_comb begin
    nextState = state;
    cntLoad   = '0;
    unique case (state)
      Idle:    if (iRunStart) nextState = IdxSu;
      IdxSu:   if (cnt == '0) nextState = IdxPw;
      IdxPw:   if (cnt == '0) nextState = IdxHd;
      IdxHd:   if (cnt == '0) nextState = Gap;
      Gap:     if (cnt == '0) nextState = DatSu;
      DatSu:   if (cnt == '0) nextState = DatPw;
      DatPw:   if (cnt == '0) nextState = DatHd;
      DatHd:   if (cnt == '0) nextState = iRunStart ? Done : Idle;
      Done:    if (!iRunStart) nextState = Idle;
      default: nextState = Idle;
    endcase
    unique case (nextState)
      IdxSu, DatSu: cntLoad = CntW'(TSU - 1);
      IdxPw, DatPw: cntLoad = CntW'(TPW - 1);
      IdxHd, DatHd: cntLoad = CntW'(THD - 1);
      Gap:          cntLoad = CntW'(TGAP - 1);
      default:      cntLoad = '0;
    endcase
  end

  // Output decode from the upcoming state so the pins register in step with it
  always_comb begin
    runEndNext = 1'b0;
    busyNext   = (nextState != Idle);
    csNNext    = 1'b1;
    cmdNext    = 1'b0;
    iowNNext   = 1'b1;
    sdNext     = oSd;
    sdOeNext   = 1'b0;
    unique case (nextState)
      IdxSu, IdxPw, IdxHd: begin
        csNNext  = 1'b0;
        sdOeNext = 1'b1;
        iowNNext = (nextState != IdxPw);
        // On the accept edge the latch is still loading, so take the input
        sdNext   = (state == Idle) ? iReg : regLatch;
      end
      DatSu, DatPw, DatHd: begin
        csNNext  = 1'b0;
        cmdNext  = 1'b1;
        sdOeNext = 1'b1;
        iowNNext = (nextState != DatPw);
        sdNext   = dataLatch;
      end
      Done:    runEndNext = 1'b1;
      default: ;
    endcase
  end

  // Request latches, loaded only when a request is accepted in Idle
  always_ff @(posedge iDm9000aClk or posedge iReset) begin
    if (iReset) begin
      regLatch  <= '0;
      dataLatch <= '0;
    end else if (state == Idle && iRunStart) begin
      regLatch  <= iReg;
      dataLatch <= iData;
    end
  end

  // Registered bus pins and handshake outputs
  always_ff @(posedge iDm9000aClk or posedge iReset) begin
    if (iReset) begin
      oRunEnd <= 1'b0;
      oBusy   <= 1'b0;
      oCs_n   <= 1'b1;
      oCmd    <= 1'b0;
      oIow_n  <= 1'b1;
      oIor_n  <= 1'b1;
      oSd     <= '0;
      oSdOe   <= 1'b0;
    end else begin
      oRunEnd <= runEndNext;
      oBusy   <= busyNext;
      oCs_n   <= csNNext;
      oCmd    <= cmdNext;
      oIow_n  <= iowNNext;
      oIor_n  <= 1'b1;
      oSd     <= sdNext;
      oSdOe   <= sdOeNext;
    end
  end

endmodule

// File: tb/tb_dm9000a_iow.sv
// Directed bench for dm9000a_iow: default-timing instance plus a slow-timing one.
`timescale 1ns/1ps
module tb_dm9000a_iow;

  logic        iDm9000aClk;
  logic        iReset;
  logic        iRunStart;
  logic [15:0] iReg;
  logic [15:0] iData;
  logic        runEnd, busy, csN, cmd, iowN, iorN, sdOe;
  logic [15:0] sd;

  logic        runStart1;
  logic [15:0] reg1, data1;
  logic        bRunEnd, bBusy, bCsN, bCmd, bIowN, bIorN, bSdOe;
  logic [15:0] bSd;

  int nCmp = 0;
  int nErr = 0;
  logic reSeen;

  dm9000a_iow u0 (
    .iDm9000aClk(iDm9000aClk), .iReset(iReset), .iRunStart(iRunStart),
    .iReg(iReg), .iData(iData), .oRunEnd(runEnd), .oBusy(busy),
    .oCs_n(csN), .oCmd(cmd), .oIow_n(iowN), .oIor_n(iorN),
    .oSd(sd), .oSdOe(sdOe)
  );

  dm9000a_iow #(.TSU(3), .TPW(5), .THD(2), .TGAP(1)) u1 (
    .iDm9000aClk(iDm9000aClk), .iReset(iReset), .iRunStart(runStart1),
    .iReg(reg1), .iData(data1), .oRunEnd(bRunEnd), .oBusy(bBusy),
    .oCs_n(bCsN), .oCmd(bCmd), .oIow_n(bIowN), .oIor_n(bIorN),
    .oSd(bSd), .oSdOe(bSdOe)
  );

  initial iDm9000aClk = 1'b0;
  always #5 iDm9000aClk = ~iDm9000aClk;

  typedef struct {
    logic        start;
    logic [15:0] rg;
    logic [15:0] dt;
    logic [21:0] exp;
  } vecT;

  typedef struct {
    int          len;
    logic [19:0] exp;   // {csN, cmd, iowN, runEnd, sd}
  } segT;

  vecT vecs[$];
  segT segs[$];

  // {csN, cmd, iowN, sdOe, runEnd, busy, sd}
  function automatic logic [21:0] pk(input logic c, input logic m, input logic w,
                                     input logic o, input logic r, input logic b,
                                     input logic [15:0] d);
    return {c, m, w, o, r, b, d};
  endfunction

  task automatic addRow(input logic s, input logic [15:0] rg, input logic [15:0] dt,
                        input logic c, input logic m, input logic w, input logic o,
                        input logic r, input logic b, input logic [15:0] d);
    vecT v;
    v.start = s; v.rg = rg; v.dt = dt; v.exp = pk(c, m, w, o, r, b, d);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iDm9000aClk);
    #1;
    reSeen = reSeen | runEnd;
  endtask

  initial begin
    int n;
    int m;
    // Transaction 1: reg 0x00, data 0x03; then drop and re-raise with 0x1F/0x81
    addRow(1, 16'h0000, 16'h0003, 0,0,1,1,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 0,0,0,1,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 0,0,0,1,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 0,0,1,1,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 1,0,1,0,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 1,0,1,0,0,1, 16'h0000);
    addRow(1, 16'h0000, 16'h0003, 0,1,1,1,0,1, 16'h0003);
    addRow(1, 16'h0000, 16'h0003, 0,1,0,1,0,1, 16'h0003);
    addRow(1, 16'h0000, 16'h0003, 0,1,0,1,0,1, 16'h0003);
    addRow(1, 16'h0000, 16'h0003, 0,1,1,1,0,1, 16'h0003);
    addRow(1, 16'h0000, 16'h0003, 1,0,1,0,1,1, 16'h0003);
    addRow(0, 16'h0000, 16'h0003, 1,0,1,0,0,0, 16'h0003);
    addRow(1, 16'h001F, 16'h0081, 0,0,1,1,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 0,0,0,1,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 0,0,0,1,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 0,0,1,1,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 1,0,1,0,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 1,0,1,0,0,1, 16'h001F);
    addRow(1, 16'h001F, 16'h0081, 0,1,1,1,0,1, 16'h0081);
    addRow(1, 16'h001F, 16'h0081, 0,1,0,1,0,1, 16'h0081);
    addRow(1, 16'h001F, 16'h0081, 0,1,0,1,0,1, 16'h0081);
    addRow(1, 16'h001F, 16'h0081, 0,1,1,1,0,1, 16'h0081);
    addRow(1, 16'h001F, 16'h0081, 1,0,1,0,1,1, 16'h0081);
    addRow(0, 16'h001F, 16'h0081, 1,0,1,0,0,0, 16'h0081);

    // Slow instance: TSU=3 TPW=5 THD=2 TGAP=1, reg 0x55, data 0xAA
    segs.push_back('{3, {1'b0, 1'b0, 1'b1, 1'b0, 16'h0055}});
    segs.push_back('{5, {1'b0, 1'b0, 1'b0, 1'b0, 16'h0055}});
    segs.push_back('{2, {1'b0, 1'b0, 1'b1, 1'b0, 16'h0055}});
    segs.push_back('{1, {1'b1, 1'b0, 1'b1, 1'b0, 16'h0055}});
    segs.push_back('{3, {1'b0, 1'b1, 1'b1, 1'b0, 16'h00AA}});
    segs.push_back('{5, {1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA}});
    segs.push_back('{2, {1'b0, 1'b1, 1'b1, 1'b0, 16'h00AA}});
    segs.push_back('{1, {1'b1, 1'b0, 1'b1, 1'b1, 16'h00AA}});

    reSeen = 1'b0;
    iReset = 1'b1; iRunStart = 1'b0; iReg = '0; iData = '0;
    runStart1 = 1'b0; reg1 = '0; data1 = '0;
    repeat (2) @(posedge iDm9000aClk);
    #1;
    chk("reset_outputs", 32'(pk(csN, cmd, iowN, sdOe, runEnd, busy, sd)),
        32'(pk(1,0,1,0,0,0,16'h0000)));
    chk("reset_ior", 32'(iorN), 32'd1);
    chk("reset_u1", 32'({bCsN, bIowN, bSdOe, bRunEnd, bBusy}), 32'b11000);
    iReset = 1'b0;

    // Table-driven default-timing transactions
    foreach (vecs[i]) begin
      iRunStart = vecs[i].start;
      iReg      = vecs[i].rg;
      iData     = vecs[i].dt;
      tick();
      chk($sformatf("vec%0d", i), 32'(pk(csN, cmd, iowN, sdOe, runEnd, busy, sd)),
          32'(vecs[i].exp));
    end

    // Request withdrawn during the index strobe: both phases complete, no RunEnd
    reSeen = 1'b0;
    iRunStart = 1'b1; iReg = 16'h1234; iData = 16'h5678;
    tick();
    chk("wd_accept_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_idx_pw", 32'({cmd, iowN, sd}), 32'({1'b0, 1'b0, 16'h1234}));
    iRunStart = 1'b0; iReg = 16'h0000; iData = 16'h0000;
    repeat (6) tick();
    chk("wd_dat_pw", 32'({cmd, iowN, sd}), 32'({1'b1, 1'b0, 16'h5678}));
    repeat (3) tick();
    chk("wd_idle", 32'({busy, csN, sdOe}), 32'b010);
    chk("wd_no_runend", 32'(reSeen), 32'd0);

    // Inputs scrambled during the gap: data phase keeps the latched value
    iRunStart = 1'b1; iReg = 16'h00AB; iData = 16'h00CD;
    repeat (5) tick();
    chk("gap_cs_high", 32'({csN, sdOe}), 32'b10);
    iReg = 16'hFFFF; iData = 16'hFFFF;
    repeat (2) tick();
    chk("gap_dat_su", 32'({cmd, sd}), 32'({1'b1, 16'h00CD}));
    tick();
    chk("gap_dat_pw", 32'({iowN, sd}), 32'({1'b0, 16'h00CD}));
    repeat (3) tick();
    chk("gap_done", 32'(runEnd), 32'd1);
    iRunStart = 1'b0;
    tick();
    chk("gap_idle", 32'(busy), 32'd0);

    // Reset during the data strobe, then a fresh transaction after release
    iRunStart = 1'b1; iReg = 16'h0002; iData = 16'h0004;
    repeat (8) tick();
    chk("rst_pre_pw", 32'({cmd, iowN}), 32'b10);
    #2 iReset = 1'b1;
    #1;
    chk("rst_async", 32'({iowN, csN, sdOe, runEnd, busy}), 32'b11000);
    @(posedge iDm9000aClk);
    #1 iReset = 1'b0;
    n = 0;
    while (n < 30) begin
      n++;
      tick();
      if (busy) break;
    end
    chk("rst_restart_accept", 32'(n), 32'd1);
    chk("rst_restart_idx", 32'({csN, cmd, sd}), 32'({1'b0, 1'b0, 16'h0002}));
    m = 0;
    while (m < 30) begin
      m++;
      tick();
      if (runEnd) break;
    end
    chk("rst_restart_latency", 32'(m), 32'd10);
    chk("rst_restart_sd", 32'(sd), 32'h0004);
    iRunStart = 1'b0;
    tick();
    chk("rst_restart_idle", 32'(busy), 32'd0);

    // Slow-timing instance: exact setup, pulse, hold, gap and latency
    runStart1 = 1'b1; reg1 = 16'h0055; data1 = 16'h00AA;
    n = 0;
    foreach (segs[s]) begin
      for (int k = 0; k < segs[s].len; k++) begin
        tick();
        chk($sformatf("slow_c%0d", n), 32'({bCsN, bCmd, bIowN, bRunEnd, bSd}),
            32'(segs[s].exp));
        n++;
      end
    end
    runStart1 = 1'b0;
    tick();
    chk("slow_idle", 32'({bBusy, bRunEnd}), 32'b00);
    chk("ior_constant", 32'({iorN, bIorN}), 32'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
